// File: rtl/sf_pkg.sv
// Definitions shared by the smoothing filter, its stream reader and their benches.
package sf_pkg;

    typedef enum logic [1:0] {SO_IDLE, SO_LOAD, SO_STREAM, SO_FINISH} sf_so_state_t;

    // Number of valid filter outputs for a record of data_len samples.
    function automatic int sf_num_out(input int data_len, input int filt_size);
        return data_len - filt_size;
    endfunction

endpackage

// File: rtl/sf_stream_out.sv
// Captures the smoothing filter result on the rising edge of sf_done and streams
// it one sample per valid/ready handshake.
module sf_stream_out
    import sf_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FILT_SIZE  = 10,
    parameter int DATA_LEN   = 100,
    localparam int NUM_OUT   = sf_num_out(DATA_LEN, FILT_SIZE),
    localparam int CNT_W     = $clog2(NUM_OUT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sf_done,
    input  logic [DATA_WIDTH-1:0] filtered_data [DATA_LEN],
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      beat_cnt
);

    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUT - 1);

    if (NUM_OUT < 1) begin : g_bad_cfg
        $error("sf_stream_out: DATA_LEN must exceed FILT_SIZE");
    end

    sf_so_state_t          state;
    logic                  sf_done_q;
    logic                  start;
    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      nxt_idx;
    logic [DATA_WIDTH-1:0] snap [NUM_OUT];

    always_comb begin
        start   = sf_done & ~sf_done_q;
        nxt_idx = rd_idx + IDX_W'(1);
    end

    // Snapshot decouples the stream from later activity of the filter.
    always_ff @(posedge clk) begin
        if (state == SO_LOAD && !flush) begin
            for (int unsigned i = 0; i < NUM_OUT; i++) begin
                snap[i] <= filtered_data[i];
            end
        end
    end

    // m_data is preloaded with the next sample so it always equals snap[rd_idx]
    // while valid; LOAD reads the input directly since snap is written that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SO_IDLE;
            sf_done_q <= 1'b0;
            rd_idx    <= '0;
            beat_cnt  <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            sf_done_q <= sf_done;
            if (flush) begin
                state   <= SO_IDLE;
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b0;
            end else begin
                case (state)
                    SO_IDLE: begin
                        done <= 1'b0;
                        if (start) begin
                            state <= SO_LOAD;
                            busy  <= 1'b1;
                        end
                    end
                    SO_LOAD: begin
                        rd_idx   <= '0;
                        beat_cnt <= '0;
                        m_valid  <= 1'b1;
                        m_data   <= filtered_data[0];
                        m_last   <= (NUM_OUT == 1);
                        state    <= SO_STREAM;
                    end
                    SO_STREAM: begin
                        if (m_ready) begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                            if (m_last) begin
                                m_valid <= 1'b0;
                                m_last  <= 1'b0;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                state   <= SO_FINISH;
                            end else begin
                                rd_idx <= nxt_idx;
                                m_data <= snap[nxt_idx];
                                m_last <= (nxt_idx == LAST_IDX);
                            end
                        end
                    end
                    SO_FINISH: begin
                        done  <= 1'b0;
                        state <= SO_IDLE;
                    end
                    default: state <= SO_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sf_stream_out.sv
// Self-checking bench for sf_stream_out: directed table, handshake corner cases
// and randomized streams against a queue-based reference.
module tb_sf_stream_out;

    localparam int DW = 8;
    localparam int FS = 4;
    localparam int DL = 16;
    localparam int NO = DL - FS;

    logic          clk = 1'b0;
    logic          rst;
    logic          sf_done;
    logic          flush;
    logic          m_ready;
    logic          m_valid;
    logic          m_last;
    logic          busy;
    logic          done;
    logic [DW-1:0] m_data;
    logic [3:0]    beat_cnt;
    logic [DW-1:0] filtered_data [DL];

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q [$];

    typedef struct {
        logic       rdy;
        logic       valid;
        logic [7:0] data;
        logic       last;
        logic       dn;
        logic       bsy;
        logic [3:0] cnt;
    } vec_t;
    vec_t tbl [NO + 3];

    sf_stream_out #(.DATA_WIDTH(DW), .FILT_SIZE(FS), .DATA_LEN(DL)) dut (
        .clk(clk), .rst(rst), .sf_done(sf_done), .filtered_data(filtered_data),
        .flush(flush), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .busy(busy), .done(done), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    property p_hold;
        @(posedge clk) disable iff (rst)
            (m_valid && !m_ready && !flush) |=> (m_valid && $stable(m_data) && $stable(m_last));
    endproperty
    a_hold: assert property (p_hold)
        else begin
            errors++;
            $display("FAIL hold_assert m_data=%0h m_last=%0b", m_data, m_last);
        end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // kind 0: value = base + i; kind 1: random. Reference queue holds the first NO values.
    task automatic fill(input int kind, input logic [7:0] base);
        exp_q = {};
        for (int i = 0; i < DL; i++) begin
            filtered_data[i] = (kind == 0) ? 8'(base + i) : 8'($urandom_range(0, 255));
            if (i < NO) exp_q.push_back(filtered_data[i]);
        end
    endtask

    task automatic trigger();
        sf_done = 1'b0;
        @(negedge clk);
        sf_done = 1'b1;
    endtask

    // mode 0: ready always, 1: pattern 1,0,0,1, 2: random. scramble rewrites the filter array mid-stream.
    task automatic run_stream(input int mode, input bit scramble, input string tag);
        int cyc = 0;
        bit prev_stall = 1'b0;
        bit fin = 1'b0;
        bit seen = 1'b0;
        logic [DW-1:0] pd = '0;
        logic pl = 1'b0;
        logic [DW-1:0] e;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (scramble && m_valid)
                for (int i = 0; i < DL; i++) filtered_data[i] = 8'($urandom_range(0, 255));
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (done) check({tag, "_early_done"}, done, 0);
            if (m_valid && !seen) begin
                seen = 1'b1;
                check({tag, "_latency"}, cyc, 2);
            end
            if (prev_stall) begin
                check({tag, "_stall_valid"}, m_valid, 1);
                check({tag, "_stall_data"}, m_data, pd);
                check({tag, "_stall_last"}, m_last, pl);
            end
            if (m_valid && m_ready) begin
                e = exp_q.pop_front();
                check({tag, "_data"}, m_data, e);
                check({tag, "_last"}, m_last, exp_q.size() == 0);
                prev_stall = 1'b0;
                if (exp_q.size() == 0) fin = 1'b1;
            end else begin
                prev_stall = m_valid;
                pd = m_data;
                pl = m_last;
            end
        end
        if (!fin) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            @(negedge clk);
            check({tag, "_done"}, done, 1);
            check({tag, "_valid_drop"}, m_valid, 0);
            check({tag, "_beat_cnt"}, beat_cnt, NO);
            @(negedge clk);
            check({tag, "_done_once"}, done, 0);
            check({tag, "_idle"}, busy, 0);
        end
        m_ready = 1'b0;
    endtask

    initial begin
        int n;
        bit seen;

        for (int r = 0; r < NO + 3; r++) begin
            tbl[r].rdy   = 1'b1;
            tbl[r].valid = (r >= 1 && r <= NO);
            tbl[r].data  = (r >= 1 && r <= NO) ? 8'(r) : 8'h00;
            tbl[r].last  = (r == NO);
            tbl[r].dn    = (r == NO + 1);
            tbl[r].bsy   = (r <= NO);
            tbl[r].cnt   = (r == 0) ? 4'd0 : (r <= NO) ? 4'(r - 1) : 4'(NO);
        end

        rst = 1'b1; sf_done = 1'b0; flush = 1'b0; m_ready = 1'b0;
        for (int i = 0; i < DL; i++) filtered_data[i] = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", m_valid, 0);
        check("rst_last", m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data", m_data, 0);
        check("rst_cnt", beat_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: table-driven back-to-back stream
        fill(0, 8'd1);
        trigger();
        for (int r = 0; r < NO + 3; r++) begin
            @(negedge clk);
            m_ready = tbl[r].rdy;
            check("t1_valid", m_valid, tbl[r].valid);
            check("t1_busy", busy, tbl[r].bsy);
            check("t1_done", done, tbl[r].dn);
            check("t1_cnt", beat_cnt, tbl[r].cnt);
            if (tbl[r].valid) begin
                check("t1_data", m_data, tbl[r].data);
                check("t1_last", m_last, tbl[r].last);
            end
        end
        m_ready = 1'b0;

        // 2: stalls with ready pattern 1,0,0,1
        fill(0, 8'd1);
        trigger();
        run_stream(1, 1'b0, "t2");

        // 3: level-high sf_done must not retrigger; a new edge streams new data
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            m_ready = 1'b1;
            if (m_valid || busy) seen = 1'b1;
        end
        check("t3_no_retrigger", seen, 0);
        fill(0, 8'hF0);
        trigger();
        run_stream(0, 1'b0, "t3");

        // 4: async reset after 5 beats
        fill(0, 8'd1);
        trigger();
        n = 0;
        for (int c = 0; c < 50 && n < 5; c++) begin
            @(negedge clk);
            m_ready = 1'b1;
            if (m_valid) n++;
        end
        check("t4_beats", n, 5);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t4_valid", m_valid, 0);
        check("t4_busy", busy, 0);
        check("t4_done", done, 0);
        check("t4_cnt", beat_cnt, 0);
        sf_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done || m_valid) seen = 1'b1;
        end
        check("t4_no_done", seen, 0);
        fill(0, 8'd1);
        trigger();
        run_stream(0, 1'b0, "t4");

        // 5: flush on beat 7 with a coincident start
        fill(0, 8'd1);
        trigger();
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            m_ready = 1'b1;
            if (c == 2) sf_done = 1'b0;
            if (m_valid && m_data == 8'd7) begin
                flush = 1'b1;
                sf_done = 1'b1;
                seen = 1'b1;
            end
        end
        check("t5_reached_beat7", seen, 1);
        @(negedge clk);
        flush = 1'b0;
        check("t5_valid", m_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_cnt", beat_cnt, 6);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (m_valid || busy || done) seen = 1'b1;
        end
        check("t5_start_dropped", seen, 0);
        m_ready = 1'b0;

        // 6: filter array changes during the stream
        fill(0, 8'h40);
        trigger();
        run_stream(1, 1'b1, "t6");

        // randomized data and ready against the reference queue
        for (int k = 0; k < 8; k++) begin
            fill(1, 8'h00);
            trigger();
            run_stream(2, 1'($urandom_range(0, 1)), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
